// File: rtl/instruction_test_checker.sv
// ---------------------------------------------------------------------------
// instruction_test_checker
// Sequences one per-instruction regression test: pulses the core's start,
// waits for core_done or a programmable timeout, then scans the core register
// file one entry per cycle against an expected table with per-bit masks and
// reports pass/fail, mismatch count and the first failing register.
//
// Optional feature (macro CHECKER_STOP_ON_FIRST_FAIL_EN): the scan ends at the
// first masked mismatch instead of covering every register.
//
// Ports:
//   i_clock, i_reset        clock (rising edge), async active-high reset
//   i_run                   start request, honoured in IDLE or REPORT
//   o_core_start            one-cycle start pulse to the core
//   i_core_done             early completion from the core
//   o_rd_index              register index for reg-file snoop / expected table
//   i_rd_data               actual register value at o_rd_index
//   i_exp_data, i_exp_mask  expected value and compare mask at o_rd_index
//   o_busy, o_done          high in START/RUN/SCAN, high in REPORT
//   o_passed, o_timed_out   result flags, valid while o_done
//   o_run_cycles            RUN cycles elapsed
//   o_mismatch_count        masked mismatches found
//   o_first_fail_index      index of the first mismatch (0 if none)
//   o_first_fail_actual     rd_data at the first mismatch (0 if none)
// ---------------------------------------------------------------------------
module instruction_test_checker #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned REG_INDEX_BITS = 5,
    parameter int unsigned TIMEOUT        = 100,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_run,
    output logic                      o_core_start,
    input  logic                      i_core_done,
    output logic [REG_INDEX_BITS-1:0] o_rd_index,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    input  logic [DATA_WIDTH-1:0]     i_exp_data,
    input  logic [DATA_WIDTH-1:0]     i_exp_mask,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_passed,
    output logic                      o_timed_out,
    output logic [CNT_BITS-1:0]       o_run_cycles,
    output logic [REG_INDEX_BITS:0]   o_mismatch_count,
    output logic [REG_INDEX_BITS-1:0] o_first_fail_index,
    output logic [DATA_WIDTH-1:0]     o_first_fail_actual
);

    localparam logic [REG_INDEX_BITS-1:0] LAST_IDX  = REG_INDEX_BITS'(NUM_REGS - 1);
    localparam logic [REG_INDEX_BITS:0]   MAX_COUNT = (REG_INDEX_BITS + 1)'(NUM_REGS);
    localparam logic [CNT_BITS-1:0]       LAST_RUN  = CNT_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_SCAN,
        S_REPORT
    } state_t;

    state_t r_state;

    logic                    w_launch;
    logic                    w_mismatch;
    logic                    w_scan_last;
    logic [REG_INDEX_BITS:0] w_count_next;

    // A new test may only be launched from IDLE or REPORT; run while busy is dropped.
    assign w_launch   = i_run && ((r_state == S_IDLE) || (r_state == S_REPORT));
    assign w_mismatch = |((i_rd_data ^ i_exp_data) & i_exp_mask);

    // Saturating mismatch counter value if the current entry mismatches.
    assign w_count_next = w_mismatch ?
                          ((o_mismatch_count == MAX_COUNT) ? o_mismatch_count
                                                           : o_mismatch_count + (REG_INDEX_BITS + 1)'(1))
                          : o_mismatch_count;

`ifdef CHECKER_STOP_ON_FIRST_FAIL_EN
    // Leave SCAN at the first mismatching entry.
    assign w_scan_last = (o_rd_index == LAST_IDX) || w_mismatch;
`else
    assign w_scan_last = (o_rd_index == LAST_IDX);
`endif

    // Sequencer FSM with registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state             <= S_IDLE;
            o_core_start        <= 1'b0;
            o_rd_index          <= '0;
            o_busy              <= 1'b0;
            o_done              <= 1'b0;
            o_passed            <= 1'b0;
            o_timed_out         <= 1'b0;
            o_run_cycles        <= '0;
            o_mismatch_count    <= '0;
            o_first_fail_index  <= '0;
            o_first_fail_actual <= '0;
        end else begin
            o_core_start <= 1'b0;
            if (w_launch) begin
                r_state             <= S_START;
                o_core_start        <= 1'b1;
                o_busy              <= 1'b1;
                o_done              <= 1'b0;
                o_passed            <= 1'b0;
                o_timed_out         <= 1'b0;
                o_run_cycles        <= '0;
                o_rd_index          <= '0;
                o_mismatch_count    <= '0;
                o_first_fail_index  <= '0;
                o_first_fail_actual <= '0;
            end else begin
                case (r_state)
                    S_START: begin
                        // core_done is deliberately not looked at here.
                        o_run_cycles <= '0;
                        r_state      <= S_RUN;
                    end
                    S_RUN: begin
                        o_run_cycles <= o_run_cycles + CNT_BITS'(1);
                        // core_done wins over a coincident timeout.
                        if (i_core_done) begin
                            o_timed_out <= 1'b0;
                            o_rd_index  <= '0;
                            r_state     <= S_SCAN;
                        end else if (o_run_cycles == LAST_RUN) begin
                            o_timed_out <= 1'b1;
                            o_rd_index  <= '0;
                            r_state     <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        o_mismatch_count <= w_count_next;
                        if (w_mismatch && (o_mismatch_count == '0)) begin
                            o_first_fail_index  <= o_rd_index;
                            o_first_fail_actual <= i_rd_data;
                        end
                        if (w_scan_last) begin
                            o_busy   <= 1'b0;
                            o_done   <= 1'b1;
                            o_passed <= (w_count_next == '0);
                            r_state  <= S_REPORT;
                        end else begin
                            o_rd_index <= o_rd_index + REG_INDEX_BITS'(1);
                        end
                    end
                    S_REPORT: r_state <= S_REPORT;
                    S_IDLE:   r_state <= S_IDLE;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_test_checker.sv
// ---------------------------------------------------------------------------
// tb_instruction_test_checker
// Drives instruction_test_checker with directed and randomized tests. Each
// test's expected cycle timeline and results are derived from the register
// tables and the core_done cycle with plain arithmetic, and the DUT outputs
// are compared against them every cycle of the test.
// ---------------------------------------------------------------------------
module tb_instruction_test_checker;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned IB = 5;
    localparam int unsigned TO = 100;
    localparam int unsigned CB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          core_start;
    logic          core_done;
    logic [IB-1:0] rd_index;
    logic [DW-1:0] rd_data, exp_data, exp_mask;
    logic          busy, done, passed, timed_out;
    logic [CB-1:0] run_cycles;
    logic [IB:0]   mismatch_count;
    logic [IB-1:0] first_fail_index;
    logic [DW-1:0] first_fail_actual;

    logic [DW-1:0] act_m [NR];
    logic [DW-1:0] exp_m [NR];
    logic [DW-1:0] msk_m [NR];

    int vectors    = 0;
    int miscompares = 0;
    int last_latency;

    always #5 clk = ~clk;

    assign rd_data  = act_m[rd_index];
    assign exp_data = exp_m[rd_index];
    assign exp_mask = msk_m[rd_index];

    instruction_test_checker #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .REG_INDEX_BITS(IB), .TIMEOUT(TO), .CNT_BITS(CB)
    ) dut (
        .i_clock(clk), .i_reset(reset), .i_run(run), .o_core_start(core_start),
        .i_core_done(core_done), .o_rd_index(rd_index), .i_rd_data(rd_data),
        .i_exp_data(exp_data), .i_exp_mask(exp_mask), .o_busy(busy), .o_done(done),
        .o_passed(passed), .o_timed_out(timed_out), .o_run_cycles(run_cycles),
        .o_mismatch_count(mismatch_count), .o_first_fail_index(first_fail_index),
        .o_first_fail_actual(first_fail_actual)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_rd_index"}, rd_index, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_passed"}, passed, 0);
        check({tag, "_timed_out"}, timed_out, 0);
        check({tag, "_run_cycles"}, run_cycles, 0);
        check({tag, "_mm_count"}, mismatch_count, 0);
        check({tag, "_ff_index"}, first_fail_index, 0);
        check({tag, "_ff_actual"}, first_fail_actual, 0);
    endtask

    // Register tables where every entry matches; x0 is 0 with a full mask.
    task automatic fill_pass();
        for (int i = 0; i < NR; i++) begin
            act_m[i] = $urandom;
            exp_m[i] = act_m[i];
            msk_m[i] = '1;
        end
        act_m[0]  = '0;
        exp_m[0]  = '0;
        act_m[11] = 32'h0000_1000;
        exp_m[11] = 32'h0000_1000;
        act_m[16] = 32'hffff_e800;
        exp_m[16] = 32'hffff_e800;
    endtask

    // One complete test. k = RUN cycle in which core_done is pulsed (-1: never).
    task automatic run_test(input int k, input bit done_in_start, input bit busy_runs);
        int mm[$];
        int scan_len, run_len, lat, exp_cnt;
        bit exp_to;
        logic [IB-1:0] exp_ffi;
        logic [DW-1:0] exp_ffa;

        for (int i = 0; i < NR; i++)
            if (((act_m[i] ^ exp_m[i]) & msk_m[i]) != '0) mm.push_back(i);
`ifdef CHECKER_STOP_ON_FIRST_FAIL_EN
        scan_len = (mm.size() > 0) ? mm[0] + 1 : NR;
        exp_cnt  = (mm.size() > 0) ? 1 : 0;
`else
        scan_len = NR;
        exp_cnt  = mm.size();
`endif
        if (k >= 0 && k <= int'(TO) - 1) begin
            run_len = k + 1;
            exp_to  = 1'b0;
        end else begin
            run_len = TO;
            exp_to  = 1'b1;
        end
        lat     = 1 + run_len + scan_len;
        exp_ffi = (mm.size() > 0) ? IB'(mm[0]) : '0;
        exp_ffa = (mm.size() > 0) ? act_m[mm[0]] : '0;

        @(negedge clk);
        run       = 1'b1;
        core_done = 1'b0;
        @(negedge clk);
        run = 1'b0;
        last_latency = -1;
        // Cycle c is the c-th cycle after the edge that sampled run.
        for (int c = 1; c <= lat + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (done && last_latency < 0) last_latency = c - 1;
            check("core_start", core_start, (c == 1));
            check("busy", busy, (c <= lat));
            check("done", done, (c == lat + 1));
            core_done = (c == 1 && done_in_start) || (k >= 0 && c == k + 2);
            run       = busy_runs && (c <= lat) && ($urandom_range(0, 3) == 0);
        end
        core_done = 1'b0;
        run       = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (r > 0) @(negedge clk);
            check("rep_done", done, 1);
            check("rep_passed", passed, (exp_cnt == 0));
            check("rep_timed_out", timed_out, exp_to);
            check("rep_run_cycles", run_cycles, run_len);
            check("rep_mm_count", mismatch_count, exp_cnt);
            check("rep_ff_index", first_fail_index, exp_ffi);
            check("rep_ff_actual", first_fail_actual, exp_ffa);
        end
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        core_done = 1'b0;
        fill_pass();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Pass with timeout, run pulses and an ignored core_done in START.
        fill_pass();
        run_test(-1, 1'b1, 1'b1);
        check("lit_to_latency", last_latency, 133);
        check("lit_to_run_cycles", run_cycles, 100);
        check("lit_to_timed_out", timed_out, 1);
        check("lit_to_passed", passed, 1);

        // Early core_done at RUN cycle 9.
        run_test(9, 1'b0, 1'b0);
        check("lit_early_latency", last_latency, 43);
        check("lit_early_run_cycles", run_cycles, 10);
        check("lit_early_timed_out", timed_out, 0);

        // Two mismatches at x12 and x17.
        fill_pass();
        act_m[12] = 32'h8000_0001; exp_m[12] = 32'h8000_0000;
        act_m[17] = 32'h0000_0000; exp_m[17] = 32'hffff_f000;
        run_test(5, 1'b0, 1'b0);
        check("lit_mm_passed", passed, 0);
        check("lit_mm_ff_index", first_fail_index, 12);
        check("lit_mm_ff_actual", first_fail_actual, 32'h8000_0001);
`ifdef CHECKER_STOP_ON_FIRST_FAIL_EN
        check("lit_mm_count", mismatch_count, 1);
        check("lit_mm_latency", last_latency, 1 + 6 + 13);
`else
        check("lit_mm_count", mismatch_count, 2);
        check("lit_mm_latency", last_latency, 1 + 6 + 32);
`endif

        // Difference hidden by the mask.
        fill_pass();
        act_m[15] = 32'h7fff_ffff; exp_m[15] = 32'h7fff_fff0; msk_m[15] = 32'hffff_fff0;
        run_test(20, 1'b0, 1'b1);
        check("lit_mask_passed", passed, 1);

        // core_done coincident with the timeout cycle.
        run_test(int'(TO) - 1, 1'b0, 1'b0);
        check("lit_coinc_timed_out", timed_out, 0);
        check("lit_coinc_run_cycles", run_cycles, 100);

        // Reset while scanning index 20.
        fill_pass();
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        repeat (121) @(negedge clk);
        check("pre_reset_rd_index", rd_index, 20);
        check("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_reset_core_start", core_start, 0);
            check("post_reset_busy", busy, 0);
        end
        run_test(3, 1'b0, 1'b1);

        // Randomized tests.
        for (int t = 0; t < 10; t++) begin
            int nflip, idx, k;
            for (int i = 0; i < NR; i++) begin
                act_m[i] = $urandom;
                exp_m[i] = act_m[i];
                msk_m[i] = ($urandom_range(0, 1) == 1) ? '1 : DW'($urandom);
            end
            act_m[0] = '0; exp_m[0] = '0; msk_m[0] = '1;
            nflip = $urandom_range(0, 3);
            for (int f = 0; f < nflip; f++) begin
                idx = $urandom_range(0, NR - 1);
                act_m[idx] = act_m[idx] ^ (DW'(1) << $urandom_range(0, DW - 1));
            end
            k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 110)) : -1;
            run_test(k, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_test_checker.md
Name: instruction_test_checker

Overview:
- Hardware sequencer and checker for the per-instruction regression benches.
- Pulses the core's start, then waits for a programmable timeout or an early core_done.
- Then scans the core register file one entry per cycle against an expected-value table with per-bit masks.
- Reports pass/fail, mismatch count and the first failing register.
- Generalises the fixed 32x32 compare-after-fixed-delay check to any register count/width, with early termination and masked compare.

Parameters:
- DATA_WIDTH, 32, register and expected-value width
- NUM_REGS, 32, number of register-file entries scanned (2..2^REG_INDEX_BITS)
- REG_INDEX_BITS, 5, width of register index
- TIMEOUT, 100, max RUN cycles before scan is forced (>=1)
- CNT_BITS, 16, width of RUN cycle counter (must hold TIMEOUT)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- run  input  1  request to start a test; sampled in IDLE or REPORT
- core_start  output  1  one-cycle start pulse to the core
- core_done  input  1  early completion from core (e.g. ecall/halt)
- rd_index  output  REG_INDEX_BITS  register index presented to core reg-file snoop and expected table
- rd_data  input  DATA_WIDTH  actual register value at rd_index (combinational, same cycle)
- exp_data  input  DATA_WIDTH  expected value at rd_index (combinational, same cycle)
- exp_mask  input  DATA_WIDTH  compare mask; 1 = bit checked
- busy  output  1  high in START, RUN, SCAN
- done  output  1  high in REPORT
- passed  output  1  valid while done; 1 = zero mismatches
- timed_out  output  1  valid while done; 1 = RUN ended by TIMEOUT, not core_done
- run_cycles  output  CNT_BITS  RUN cycles elapsed
- mismatch_count  output  REG_INDEX_BITS+1  masked mismatches found
- first_fail_index  output  REG_INDEX_BITS  index of first mismatch (0 if none)
- first_fail_actual  output  DATA_WIDTH  rd_data at first mismatch (0 if none)

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including rd_index, counters and result registers.
- FSM states: IDLE, START, RUN, SCAN, REPORT.
- IDLE:
  - run=1 -> START; result registers cleared on the transition.
- START:
  - core_start=1 for exactly this one cycle; run_cycles cleared.
  - -> RUN next cycle.
  - core_done is ignored in START.
- RUN:
  - run_cycles increments each cycle.
  - If core_done=1 -> SCAN with timed_out=0.
  - Else if run_cycles==TIMEOUT-1 -> SCAN with timed_out=1.
  - If both occur in the same cycle, core_done has priority (timed_out=0).
  - rd_index is set to 0 on entry to SCAN.
- SCAN: one index per cycle, index 0 to NUM_REGS-1.
  - Mismatch when ((rd_data ^ exp_data) & exp_mask) != 0.
  - On a mismatch: mismatch_count increments, saturating at NUM_REGS.
  - On the first mismatch only: first_fail_index and first_fail_actual are captured.
  - At index NUM_REGS-1 -> REPORT; rd_index holds its last value.
  - Total scan latency is exactly NUM_REGS cycles.
- REPORT:
  - done=1; passed = (mismatch_count==0); all results held.
  - run=1 -> START; results cleared; done drops next cycle.
- run while busy is ignored and not queued.
- Total latency from run to done, core_done at RUN cycle k (k from 0): 1 (START) + k+1 (RUN) + NUM_REGS (SCAN).
- Timeout case: 1 + TIMEOUT + NUM_REGS.
- Index 0 is scanned like any other entry; expected table supplies 0 with mask all-ones for x0.
- Reset asserted mid-RUN or mid-SCAN aborts immediately. core_start is never re-pulsed until a new run.

Optional Feature:
- Macro: CHECKER_STOP_ON_FIRST_FAIL_EN.
- Defined:
  - SCAN exits to REPORT in the cycle after the first mismatch is detected.
  - mismatch_count is then 0 or 1.
  - Scan latency equals first_fail_index+1 on failure, NUM_REGS on pass.
- Undefined: full scan always runs, as described above.

Test Plan:
- Pass, timeout:
  - Stimulus: TIMEOUT=100, NUM_REGS=32, core_done held 0; all rd_data equal exp_data (e.g. a1=0x00001000, a6=0xffffe800); mask all-ones.
  - Required: core_start pulses 1 cycle after run; done 133 cycles after run; passed=1, timed_out=1, run_cycles=100, mismatch_count=0.
- Early done:
  - Stimulus: core_done pulsed at RUN cycle 9.
  - Required: timed_out=0, run_cycles=10; done 1+10+32 cycles after run.
- Two mismatches:
  - Stimulus: reg 12 actual 0x80000001 vs expected 0x80000000; reg 17 actual 0 vs 0xfffff000.
  - Required: passed=0, mismatch_count=2, first_fail_index=12, first_fail_actual=0x80000001.
  - With CHECKER_STOP_ON_FIRST_FAIL_EN: done arrives 13 cycles into SCAN, mismatch_count=1.
- Masked compare:
  - Stimulus: reg 15 actual 0x7fffffff, expected 0x7ffffff0, mask 0xfffffff0.
  - Required: passed=1.
- Timeout and core_done in the same cycle:
  - Stimulus: core_done=1 exactly at run_cycles==TIMEOUT-1.
  - Required: timed_out=0.
- Reset and busy handling:
  - Stimulus: reset asserted at SCAN index 20.
  - Required: all outputs 0 asynchronously, state IDLE; a new run yields a clean full result.
  - run pulses while busy have no effect.
